rv0_ct_ctrl: RTL and testbench
==============================

# rv0_ct_ctrl

Control-transfer sequencer between the execute-stage branch ALU and the fetch unit. It takes the resolved JAL/JALR/BRANCH outcome (taken flag and target), stalls execute while a redirect is outstanding, drives a valid/ready redirect request to fetch and flushes the front-end for a fixed drain window. Taken targets that are not 4-byte aligned are diverted to the trap unit as an instruction-address-misaligned exception instead of redirecting fetch.

## Interface

Parameters:
- XLEN, 32, datapath/address width (from core parameter list)
- FLUSH_CYCLES, 2, front-end drain cycles after redirect handshake (0..7)

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  reset; synchronous, active-low
- ex_valid_i  in  1  execute stage holds a valid instruction
- ex_ct_i  in  1  that instruction is JAL, JALR or BRANCH
- ex_addr_i  in  XLEN  PC of the execute instruction
- alu_ct_trans_i  in  1  branch ALU: control transfer taken
- alu_ct_target_i  in  XLEN  branch ALU: transfer target
- ex_stall_o  out  1  hold execute stage
- ex_ack_o  out  1  pulse: ct instruction retires from execute
- ex_kill_o  out  1  pulse: ct instruction discarded (trap)
- fch_redir_valid_o  out  1  redirect request to fetch
- fch_redir_addr_o  out  XLEN  redirect PC
- fch_redir_ready_i  in  1  fetch accepts redirect
- pipe_flush_o  out  1  kill IF/ID contents
- trap_valid_o  out  1  misaligned-target exception request
- trap_epc_o  out  XLEN  PC of faulting ct instruction
- trap_tval_o  out  XLEN  faulting target
- trap_ack_i  in  1  trap unit accepts exception
- ct_cnt_o  out  32  resolved ct instructions (taken, not-taken, trapped)
- ct_taken_cnt_o  out  32  successful redirects

## Operation

- States: IDLE, REDIRECT, FLUSH, TRAP. Reset (rst_ni=0 at edge) forces IDLE from any state; all outputs and both counters 0, latched target/EPC 0.
- Accept: IDLE & ex_valid_i & ex_ct_i.
  - not taken: ex_ack_o=1 combinationally same cycle, ct_cnt_o+1 next cycle, stay IDLE.
  - taken, alu_ct_target_i[1:0]==0: latch target, go REDIRECT.
  - taken, alu_ct_target_i[1:0]!=0: latch target as tval and ex_addr_i as EPC, go TRAP.
- REDIRECT: fch_redir_valid_o=1, fch_redir_addr_o=latched target, pipe_flush_o=1, ex_stall_o=1. Valid and addr held stable until fch_redir_ready_i. Handshake cycle: ex_ack_o=1, ex_stall_o=0, ct_cnt_o and ct_taken_cnt_o +1; next state FLUSH (IDLE if FLUSH_CYCLES=0).
- FLUSH: 3-bit down-counter loaded with FLUSH_CYCLES-1; pipe_flush_o=1, ex_stall_o=0, ex_valid_i ignored (no accept); exit to IDLE when counter is 0.
- TRAP: trap_valid_o=1, trap_epc_o/trap_tval_o stable, ex_stall_o=1, no fetch redirect. trap_ack_i cycle: ex_kill_o=1, ex_stall_o=0, ct_cnt_o+1, next IDLE (trap unit owns the fetch redirect).
- Outside the stated cases every output is 0; fch_redir_addr_o, trap_epc_o, trap_tval_o show latched values (0 after reset).
- Counters wrap 0xFFFF_FFFF -> 0, registered, updated on the cycle after the event.
- ex_ack_o and ex_kill_o are mutually exclusive and at most one per ct instruction.
- ex_ct_i with ex_valid_i=0 is ignored; alu_ct_* are don't-care unless accepting.

## Timing

- Not taken: ack in accept cycle N; back-to-back ct instructions accepted every cycle.
- Taken: accept N; REDIRECT from N+1; ready already high at N+1 gives handshake at N+1 (minimum redirect latency 1 cycle); pipe_flush_o high N+1 through handshake+FLUSH_CYCLES inclusive; next accept earliest at handshake+FLUSH_CYCLES+1.
- Misaligned: trap_valid_o from N+1; trap_ack_i at N+1 allowed; IDLE at N+2.
- Stall deasserts in the same cycle as the ack/kill pulse so execute advances exactly once.
- rst_ni low mid-REDIRECT drops fch_redir_valid_o at that edge (reset overrides handshake rule).
- No combinational path from fch_redir_ready_i or trap_ack_i to fch_redir_valid_o or trap_valid_o.

## Test plan

- BEQ not taken (ex_addr_i=0x100, trans=0): ex_ack_o=1 same cycle, no flush, ct_cnt_o=1, ct_taken_cnt_o=0; second BEQ next cycle also acked.
- JAL taken to 0x200, ready high at N+1: redirect valid/addr=0x200 at N+1, ack N+1, pipe_flush_o N+1..N+3 (FLUSH_CYCLES=2), accept again at N+4.
- BNE taken to 0x80, ready held low 5 cycles: valid/addr stable 6 cycles, ex_stall_o=1 until ready, single ex_ack_o.
- JALR target 0x102 from ex_addr_i=0x40: trap_valid_o, epc=0x40, tval=0x102, no fch_redir_valid_o; trap_ack_i after 3 cycles -> ex_kill_o pulse, ct_taken_cnt_o unchanged.
- rst_ni low during REDIRECT and during FLUSH: all outputs 0 next cycle, counters 0, IDLE; new taken JAL after reset redirects normally.
- FLUSH_CYCLES=0 and ct_cnt_o preloaded near 0xFFFF_FFFF via 2^32 stimulus-free force: IDLE directly after handshake; counter wraps to 0.

Source files
------------

// File: rtl/rv0_ct_ctrl.sv
// Control-transfer sequencer: turns resolved JAL/JALR/BRANCH outcomes into
// fetch redirects with a front-end drain window, or misaligned-target traps.
module rv0_ct_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ex_valid_i,
    input  logic            ex_ct_i,
    input  logic [XLEN-1:0] ex_addr_i,
    input  logic            alu_ct_trans_i,
    input  logic [XLEN-1:0] alu_ct_target_i,
    output logic            ex_stall_o,
    output logic            ex_ack_o,
    output logic            ex_kill_o,
    output logic            fch_redir_valid_o,
    output logic [XLEN-1:0] fch_redir_addr_o,
    input  logic            fch_redir_ready_i,
    output logic            pipe_flush_o,
    output logic            trap_valid_o,
    output logic [XLEN-1:0] trap_epc_o,
    output logic [XLEN-1:0] trap_tval_o,
    input  logic            trap_ack_i,
    output logic [31:0]     ct_cnt_o,
    output logic [31:0]     ct_taken_cnt_o
);

    localparam int unsigned CntW = 32;
    localparam int unsigned FcW  = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2,
        TRAP     = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [FcW-1:0]    flush_cnt_q, flush_cnt_d;
    logic [XLEN-1:0]   redir_addr_q, redir_addr_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [XLEN-1:0]   tval_q, tval_d;
    logic              redir_valid_q, redir_valid_d;
    logic              flush_q, flush_d;
    logic              trap_valid_q, trap_valid_d;
    logic [CntW-1:0]   ct_cnt_q, ct_cnt_d;
    logic [CntW-1:0]   taken_cnt_q, taken_cnt_d;

    logic accept, misaligned, handshake, trap_done;

    // Event decode; ack/kill/stall must react in the same cycle as the inputs
    always_comb begin
        accept     = (state_q == IDLE) && ex_valid_i && ex_ct_i;
        misaligned = (alu_ct_target_i[1:0] != 2'b00);
        handshake  = (state_q == REDIRECT) && fch_redir_ready_i;
        trap_done  = (state_q == TRAP) && trap_ack_i;
        ex_ack_o   = (accept && !alu_ct_trans_i) || handshake;
        ex_kill_o  = trap_done;
        ex_stall_o = ((state_q == REDIRECT) && !fch_redir_ready_i) ||
                     ((state_q == TRAP) && !trap_ack_i);
    end

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        redir_addr_d = redir_addr_q;
        epc_d        = epc_q;
        tval_d       = tval_q;
        ct_cnt_d     = ct_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!alu_ct_trans_i) begin
                        ct_cnt_d = ct_cnt_q + CntW'(1);
                    end else if (misaligned) begin
                        tval_d  = alu_ct_target_i;
                        epc_d   = ex_addr_i;
                        state_d = TRAP;
                    end else begin
                        redir_addr_d = alu_ct_target_i;
                        state_d      = REDIRECT;
                    end
                end
            end
            REDIRECT: begin
                if (fch_redir_ready_i) begin
                    ct_cnt_d    = ct_cnt_q + CntW'(1);
                    taken_cnt_d = taken_cnt_q + CntW'(1);
                    if (FLUSH_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = FLUSH;
                        flush_cnt_d = FcW'(FLUSH_CYCLES - 1);
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - FcW'(1);
                end
            end
            TRAP: begin
                if (trap_ack_i) begin
                    ct_cnt_d = ct_cnt_q + CntW'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Moore outputs are registered from the next state so they carry no input path
        redir_valid_d = (state_d == REDIRECT);
        flush_d       = (state_d == REDIRECT) || (state_d == FLUSH);
        trap_valid_d  = (state_d == TRAP);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            flush_cnt_q   <= '0;
            redir_addr_q  <= '0;
            epc_q         <= '0;
            tval_q        <= '0;
            redir_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            trap_valid_q  <= 1'b0;
            ct_cnt_q      <= '0;
            taken_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            redir_addr_q  <= redir_addr_d;
            epc_q         <= epc_d;
            tval_q        <= tval_d;
            redir_valid_q <= redir_valid_d;
            flush_q       <= flush_d;
            trap_valid_q  <= trap_valid_d;
            ct_cnt_q      <= ct_cnt_d;
            taken_cnt_q   <= taken_cnt_d;
        end
    end

    assign fch_redir_valid_o = redir_valid_q;
    assign fch_redir_addr_o  = redir_addr_q;
    assign pipe_flush_o      = flush_q;
    assign trap_valid_o      = trap_valid_q;
    assign trap_epc_o        = epc_q;
    assign trap_tval_o       = tval_q;
    assign ct_cnt_o          = ct_cnt_q;
    assign ct_taken_cnt_o    = taken_cnt_q;

endmodule

// File: tb/tb_rv0_ct_ctrl.sv
// Bench for rv0_ct_ctrl: directed + random stimulus against a transaction-level
// model (FLUSH_CYCLES=2), plus a FLUSH_CYCLES=0 instance for wrap/no-drain.
module tb_rv0_ct_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- main DUT (FLUSH_CYCLES = 2) ----------------
    logic        rst_ni = 1'b0;
    logic        ex_valid_i = 1'b0, ex_ct_i = 1'b0, alu_ct_trans_i = 1'b0;
    logic [31:0] ex_addr_i = '0, alu_ct_target_i = '0;
    logic        fch_redir_ready_i = 1'b0, trap_ack_i = 1'b0;
    logic        ex_stall_o, ex_ack_o, ex_kill_o, fch_redir_valid_o, pipe_flush_o, trap_valid_o;
    logic [31:0] fch_redir_addr_o, trap_epc_o, trap_tval_o, ct_cnt_o, ct_taken_cnt_o;

    rv0_ct_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid_i), .ex_ct_i(ex_ct_i), .ex_addr_i(ex_addr_i),
        .alu_ct_trans_i(alu_ct_trans_i), .alu_ct_target_i(alu_ct_target_i),
        .ex_stall_o(ex_stall_o), .ex_ack_o(ex_ack_o), .ex_kill_o(ex_kill_o),
        .fch_redir_valid_o(fch_redir_valid_o), .fch_redir_addr_o(fch_redir_addr_o),
        .fch_redir_ready_i(fch_redir_ready_i), .pipe_flush_o(pipe_flush_o),
        .trap_valid_o(trap_valid_o), .trap_epc_o(trap_epc_o), .trap_tval_o(trap_tval_o),
        .trap_ack_i(trap_ack_i), .ct_cnt_o(ct_cnt_o), .ct_taken_cnt_o(ct_taken_cnt_o)
    );

    // ---------------- second DUT (FLUSH_CYCLES = 0) ----------------
    logic        z_rst_ni = 1'b0;
    logic        z_valid = 1'b0, z_ct = 1'b0, z_trans = 1'b0;
    logic [31:0] z_addr = '0, z_tgt = '0;
    logic        z_ready = 1'b0, z_tack = 1'b0;
    logic        z_stall, z_ack, z_kill, z_rvalid, z_flush, z_tvalid;
    logic [31:0] z_raddr, z_epc, z_tval, z_cnt, z_tcnt;

    rv0_ct_ctrl #(.XLEN(32), .FLUSH_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_ni(z_rst_ni),
        .ex_valid_i(z_valid), .ex_ct_i(z_ct), .ex_addr_i(z_addr),
        .alu_ct_trans_i(z_trans), .alu_ct_target_i(z_tgt),
        .ex_stall_o(z_stall), .ex_ack_o(z_ack), .ex_kill_o(z_kill),
        .fch_redir_valid_o(z_rvalid), .fch_redir_addr_o(z_raddr),
        .fch_redir_ready_i(z_ready), .pipe_flush_o(z_flush),
        .trap_valid_o(z_tvalid), .trap_epc_o(z_epc), .trap_tval_o(z_tval),
        .trap_ack_i(z_tack), .ct_cnt_o(z_cnt), .ct_taken_cnt_o(z_tcnt)
    );

    // ---------------- behavioural model ----------------
    // Phase of the outstanding control transfer: none, waiting for fetch,
    // draining the front end (m_left cycles remain), waiting for the trap unit.
    localparam int P_NONE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_DRAIN = 2;
    localparam int P_TRAP  = 3;
    localparam int DRAIN   = 2;

    int          m_ph   = P_NONE;
    int          m_left = 0;
    logic [31:0] m_redir = '0, m_epc = '0, m_tval = '0;
    logic [31:0] m_cnt = '0, m_tcnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, compare every output to the model, advance the model.
    task automatic step(input logic rst, input logic v, input logic ct, input logic [31:0] addr,
                        input logic tr, input logic [31:0] tgt, input logic rdy, input logic tack);
        logic accept;
        @(negedge clk);
        rst_ni = rst; ex_valid_i = v; ex_ct_i = ct; ex_addr_i = addr;
        alu_ct_trans_i = tr; alu_ct_target_i = tgt;
        fch_redir_ready_i = rdy; trap_ack_i = tack;
        #1;
        accept = (m_ph == P_NONE) && v && ct;
        chk("redir_valid", 32'(fch_redir_valid_o), 32'(m_ph == P_FETCH));
        chk("pipe_flush", 32'(pipe_flush_o), 32'(m_ph == P_FETCH || m_ph == P_DRAIN));
        chk("trap_valid", 32'(trap_valid_o), 32'(m_ph == P_TRAP));
        chk("redir_addr", fch_redir_addr_o, m_redir);
        chk("trap_epc", trap_epc_o, m_epc);
        chk("trap_tval", trap_tval_o, m_tval);
        chk("ct_cnt", ct_cnt_o, m_cnt);
        chk("taken_cnt", ct_taken_cnt_o, m_tcnt);
        if (rst) begin
            chk("ex_ack", 32'(ex_ack_o), 32'((accept && !tr) || (m_ph == P_FETCH && rdy)));
            chk("ex_kill", 32'(ex_kill_o), 32'(m_ph == P_TRAP && tack));
            chk("ex_stall", 32'(ex_stall_o),
                32'((m_ph == P_FETCH && !rdy) || (m_ph == P_TRAP && !tack)));
        end
        if (!rst) begin
            m_ph = P_NONE; m_left = 0;
            m_redir = '0; m_epc = '0; m_tval = '0; m_cnt = '0; m_tcnt = '0;
        end else begin
            case (m_ph)
                P_NONE: if (accept) begin
                    if (!tr) m_cnt = m_cnt + 1;
                    else if ((tgt % 4) != 0) begin m_tval = tgt; m_epc = addr; m_ph = P_TRAP; end
                    else begin m_redir = tgt; m_ph = P_FETCH; end
                end
                P_FETCH: if (rdy) begin
                    m_cnt = m_cnt + 1; m_tcnt = m_tcnt + 1;
                    m_ph = P_DRAIN; m_left = DRAIN;
                end
                P_DRAIN: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_ph = P_NONE;
                end
                default: if (tack) begin m_cnt = m_cnt + 1; m_ph = P_NONE; end
            endcase
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] r;
        logic rs, v, ct, tr, rdy, ta;
        logic [31:0] tgt;
        repeat (2) @(posedge clk);

        // reset state
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle();
        chk("rst_valid_lit", 32'(fch_redir_valid_o), 32'h0);
        chk("rst_cnt_lit", ct_cnt_o, 32'h0);

        // two back-to-back not-taken branches
        step(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h180, 1'b0, 1'b0);
        chk("beq_ack_lit", 32'(ex_ack_o), 32'h1);
        step(1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h180, 1'b0, 1'b0);
        chk("beq2_ack_lit", 32'(ex_ack_o), 32'h1);
        chk("beq_cnt_lit", ct_cnt_o, 32'h1);
        idle();
        chk("beq_cnt2_lit", ct_cnt_o, 32'h2);
        chk("beq_taken_lit", ct_taken_cnt_o, 32'h0);

        // taken JAL with ready already high: flush N+1..N+3, accept at N+4
        step(1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h200, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("jal_valid_lit", 32'(fch_redir_valid_o), 32'h1);
        chk("jal_addr_lit", fch_redir_addr_o, 32'h200);
        chk("jal_ack_lit", 32'(ex_ack_o), 32'h1);
        repeat (2) begin
            step(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
            chk("jal_flush_lit", 32'(pipe_flush_o), 32'h1);
            chk("jal_noacc_lit", 32'(ex_ack_o), 32'h0);
        end
        step(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("jal_reacc_lit", 32'(ex_ack_o), 32'h1);
        chk("jal_cnt_lit", ct_cnt_o, 32'h3);

        // taken BNE with fetch stalled for 5 cycles
        step(1'b1, 1'b1, 1'b1, 32'h1000, 1'b1, 32'h80, 1'b0, 1'b0);
        repeat (5) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
            chk("bne_addr_lit", fch_redir_addr_o, 32'h80);
            chk("bne_stall_lit", 32'(ex_stall_o), 32'h1);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("bne_ack_lit", 32'(ex_ack_o), 32'h1);
        repeat (3) idle();
        chk("bne_taken_lit", ct_taken_cnt_o, 32'h2);

        // misaligned JALR target traps, acked after 3 cycles
        step(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h102, 1'b0, 1'b0);
        repeat (3) begin
            idle();
            chk("trap_epc_lit", trap_epc_o, 32'h40);
            chk("trap_tval_lit", trap_tval_o, 32'h102);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("trap_kill_lit", 32'(ex_kill_o), 32'h1);
        idle();
        chk("trap_taken_lit", ct_taken_cnt_o, 32'h2);
        chk("trap_cnt_lit", ct_cnt_o, 32'h6);

        // reset during REDIRECT, then during FLUSH
        step(1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 1'b0);
        idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle();
        chk("rstred_valid_lit", 32'(fch_redir_valid_o), 32'h0);
        chk("rstred_cnt_lit", ct_cnt_o, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h310, 1'b1, 32'h400, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("rst_jal_addr_lit", fch_redir_addr_o, 32'h400);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle();
        chk("rstfl_flush_lit", 32'(pipe_flush_o), 32'h0);
        chk("rstfl_taken_lit", ct_taken_cnt_o, 32'h0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rs  = ($urandom_range(0, 99) >= 3);
            v   = ($urandom_range(0, 9) < 7);
            ct  = ($urandom_range(0, 9) < 6);
            tr  = $urandom_range(0, 1) == 1;
            rdy = ($urandom_range(0, 9) < 4);
            ta  = ($urandom_range(0, 9) < 4);
            r   = $urandom;
            tgt = ($urandom_range(0, 3) != 0) ? (r & 32'hFFFF_FFFC) : r;
            step(rs, v, ct, $urandom & 32'hFFFF_FFFC, tr, tgt, rdy, ta);
        end

        // FLUSH_CYCLES=0 instance: counter preloaded to all-ones, no drain window
        @(negedge clk);
        z_rst_ni = 1'b1;
        force dut0.ct_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut0.ct_cnt_q;
        #1 chk("z_preload_lit", z_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        z_valid = 1'b1; z_ct = 1'b1; z_trans = 1'b1; z_tgt = 32'h500; z_addr = 32'h10;
        #1 chk("z_acc_noack_lit", 32'(z_ack), 32'h0);
        @(negedge clk);
        z_valid = 1'b0; z_ct = 1'b0; z_ready = 1'b1;
        #1 chk("z_valid_lit", 32'(z_rvalid), 32'h1);
        chk("z_addr_lit", z_raddr, 32'h500);
        chk("z_ack_lit", 32'(z_ack), 32'h1);
        @(negedge clk);
        z_ready = 1'b0; z_valid = 1'b1; z_ct = 1'b1; z_trans = 1'b0;
        #1 chk("z_nodrain_valid_lit", 32'(z_rvalid), 32'h0);
        chk("z_nodrain_flush_lit", 32'(z_flush), 32'h0);
        chk("z_wrap_lit", z_cnt, 32'h0);
        chk("z_taken_lit", z_tcnt, 32'h1);
        chk("z_reacc_lit", 32'(z_ack), 32'h1);
        @(negedge clk);
        z_valid = 1'b0; z_ct = 1'b0;
        #1 chk("z_cnt_after_lit", z_cnt, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
